// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, sequencer states and iteration count for the HI/LO unit
package muldiv_pkg;
    localparam int WIDTH = 32;
    localparam int MULDIV_ITER = WIDTH;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: controller/datapath connection to the multicycle HI/LO unit
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             hiloread;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    modport master (output start, op, srca, srcb, hiloread, input hi, lo, busy, stall, done);
    modport slave  (input start, op, srca, srcb, hiloread, output hi, lo, busy, stall, done);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (mode=0) or restoring-divide (mode=1) iteration
import muldiv_pkg::*;
module muldiv_step #(parameter int WIDTH = MULDIV_ITER) (
    input  logic             mode,
    input  logic [WIDTH-1:0] hin,
    input  logic [WIDTH-1:0] lin,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hout,
    output logic [WIDTH-1:0] lout
);
    logic [WIDTH:0] sum, r, diff;
    always_comb begin
        sum  = {1'b0, hin} + (lin[0] ? {1'b0, b} : '0);
        r    = {hin, lin[WIDTH-1]};
        // r < 2*b always, so the top bit of the WIDTH+1 difference is a clean borrow
        diff = r - {1'b0, b};
        hout = mode ? (diff[WIDTH] ? r[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
        lout = mode ? {lin[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lin[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multicycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO registers and stall
import muldiv_pkg::*;
module muldiv_seq #(parameter int WIDTH = MULDIV_ITER) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    state_e state, state_d;
    logic [WIDTH-1:0] hreg, lreg, breg, hstep, lstep, hi_q, lo_q, amag, bmag;
    logic [CW-1:0] cnt;
    logic neg_res, neg_rem, is_div, done_q;
    logic mul_op, div_op, sgn, div0;
    logic [2*WIDTH-1:0] prod_fix;
    always_comb begin
        mul_op   = bus.op == OP_MULT || bus.op == OP_MULTU;
        div_op   = bus.op == OP_DIV || bus.op == OP_DIVU;
        sgn      = bus.op == OP_MULT || bus.op == OP_DIV;
        div0     = div_op && bus.srcb == '0;
        amag     = sgn && bus.srca[WIDTH-1] ? -bus.srca : bus.srca;
        bmag     = sgn && bus.srcb[WIDTH-1] ? -bus.srcb : bus.srcb;
        prod_fix = neg_res ? -{hreg, lreg} : {hreg, lreg};
    end
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:       state_d = !bus.start ? S_IDLE : mul_op ? S_MUL :
                                    (div_op && !div0) ? S_DIV : S_IDLE;
            S_MUL, S_DIV: state_d = cnt == '0 ? S_FIX : state;
            S_FIX:        state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode(is_div),
        .hin (hreg),
        .lin (lreg),
        .b   (breg),
        .hout(hstep),
        .lout(lstep)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            hreg    <= '0;
            lreg    <= '0;
            breg    <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    if (mul_op || (div_op && !div0)) begin
                        hreg    <= '0;
                        lreg    <= mul_op ? bmag : amag;
                        breg    <= mul_op ? amag : bmag;
                        cnt     <= CW'(WIDTH - 1);
                        neg_res <= sgn & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
                        neg_rem <= sgn & bus.srca[WIDTH-1];
                        is_div  <= div_op;
                    end else if (div0) begin
                        hi_q   <= bus.srca;
                        lo_q   <= '1;
                        done_q <= 1'b1;
                    end else if (bus.op == OP_MTHI) begin
                        hi_q <= bus.srca;
                    end else if (bus.op == OP_MTLO) begin
                        lo_q <= bus.srca;
                    end
                end
                S_MUL, S_DIV: begin
                    hreg <= hstep;
                    lreg <= lstep;
                    cnt  <= cnt - 1'b1;
                end
                S_FIX: begin
                    done_q <= 1'b1;
                    if (is_div) begin
                        lo_q <= neg_res ? -lreg : lreg;
                        hi_q <= neg_rem ? -hreg : hreg;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = state != S_IDLE;
    assign bus.stall = bus.busy & (bus.start | bus.hiloread);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed checks of latency, results, stall, reset abort and MTHI/MTLO
import muldiv_pkg::*;
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    int n, st;
    muldiv_if #(.WIDTH(32)) bus();
    muldiv_seq #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int cycles);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.srca  = a;
        bus.srcb  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.srca  = $urandom;
        bus.srcb  = $urandom;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 3'b000;
        bus.srca = '0;
        bus.srcb = '0;
        bus.hiloread = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_done", {31'b0, bus.done}, 32'h0);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("multu_lat", n, 33);
        chk("multu_done", {31'b0, bus.done}, 32'h1);
        chk("multu_hi", bus.hi, 32'hFFFFFFFE);
        chk("multu_lo", bus.lo, 32'h00000001);
        @(negedge clk);
        chk("multu_done_pulse", {31'b0, bus.done}, 32'h0);
        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, n);
        chk("mult_lat", n, 33);
        chk("mult_hi", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo", bus.lo, 32'hFFFFFFEB);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, n);
        chk("div_lat", n, 33);
        chk("div_done", {31'b0, bus.done}, 32'h1);
        chk("div_lo", bus.lo, 32'hFFFFFFFD);
        chk("div_hi", bus.hi, 32'hFFFFFFFF);
        run_op(OP_DIVU, 32'd100, 32'd0, n);
        chk("div0_busy", n, 0);
        chk("div0_done", {31'b0, bus.done}, 32'h1);
        chk("div0_hi", bus.hi, 32'd100);
        chk("div0_lo", bus.lo, 32'hFFFFFFFF);
        @(negedge clk);
        chk("div0_done_pulse", {31'b0, bus.done}, 32'h0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        chk("minint_lo", bus.lo, 32'h80000000);
        chk("minint_hi", bus.hi, 32'h0);
        run_op(OP_MULTU, 32'd6, 32'd7, n);
        chk("mulsmall_lo", bus.lo, 32'd42);
        chk("mulsmall_hi", bus.hi, 32'd0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.srca  = 32'd1000;
        bus.srcb  = 32'd7;
        @(negedge clk);
        bus.op       = OP_MULTU;
        bus.srca     = 32'd3;
        bus.srcb     = 32'd5;
        bus.hiloread = 1'b1;
        n = 0;
        st = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (bus.stall) st++;
            if (n == 20) bus.start = 1'b0;
            @(negedge clk);
        end
        chk("stall_lat", n, 33);
        chk("stall_cycles", st, 33);
        chk("stall_done_cycle", {31'b0, bus.stall}, 32'h0);
        chk("stall_done", {31'b0, bus.done}, 32'h1);
        chk("stall_lo", bus.lo, 32'd142);
        chk("stall_hi", bus.hi, 32'd6);
        bus.hiloread = 1'b0;
        @(negedge clk);
        chk("stall_no_second", {31'b0, bus.busy}, 32'h0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.srca  = 32'd500;
        bus.srcb  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_hi", bus.hi, 32'h0);
        chk("abort_lo", bus.lo, 32'h0);
        chk("abort_done", {31'b0, bus.done}, 32'h0);
        @(negedge clk);
        chk("abort_done_after", {31'b0, bus.done}, 32'h0);
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.srca  = 32'h1234;
        @(negedge clk);
        chk("mthi_busy", {31'b0, bus.busy}, 32'h0);
        bus.op    = OP_MTLO;
        bus.srca  = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mtlo_busy", {31'b0, bus.busy}, 32'h0);
        chk("mthi_hi", bus.hi, 32'h1234);
        chk("mtlo_lo", bus.lo, 32'h5678);
        chk("mt_done", {31'b0, bus.done}, 32'h0);
        bus.start = 1'b1;
        bus.op    = 3'b111;
        bus.srca  = 32'hDEAD;
        @(negedge clk);
        bus.start = 1'b0;
        chk("inv_busy", {31'b0, bus.busy}, 32'h0);
        chk("inv_hi", bus.hi, 32'h1234);
        chk("inv_lo", bus.lo, 32'h5678);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
